exec_control: RTL and testbench
===============================

EXEC_CONTROL -- requirements
Module: exec_control

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  upstream byte valid
- instr  in  8  instruction or immediate byte
- instr_ready  out  1  block accepts byte this cycle
- alu_a  out  8  ALU operand a = reg[rd]
- alu_b  out  8  ALU operand b = reg[rs] or immediate
- alu_op  out  4  ALU opcode
- alu_result  in  8  combinational ALU result
- done  out  1  one-cycle pulse on register write
- illegal  out  1  one-cycle pulse on illegal opcode
- dbg_addr  in  2  debug register select
- dbg_data  out  8  reg[dbg_addr], combinational
- z_flag  out  1  zero flag (see Configuration)

Function
REQ-003 The block SHALL hold four 8-bit registers reg[0..3].
REQ-004 The instruction format SHALL be: [7:5] opcode, [4] ignored, [3:2] rd, [1:0] rs.
REQ-005 Opcode mapping SHALL be:
- 000 ADD -> alu_op 0000
- 001 SUB -> 0001
- 010 MOV -> 0010
- 011 AND -> 0011
- 100 OR -> 0100
- 101 LDI -> 0010, with alu_b = next byte
- 110/111 illegal
REQ-006 The FSM SHALL have the states IDLE, IMM, EXEC and WB.
REQ-007 A byte SHALL transfer only on a clock edge where instr_valid and instr_ready are both 1.
REQ-008 instr_ready SHALL be 1 in IDLE and IMM only.
REQ-009 In IDLE, accepting an ALU opcode (000-100) SHALL load alu_a=reg[rd], alu_b=reg[rs] and alu_op, then go to EXEC.
REQ-010 In IDLE, accepting LDI SHALL latch rd and go to IMM.
REQ-011 In IMM, accepting a byte SHALL load alu_b=byte, alu_a=reg[rd] and alu_op=0010, then go to EXEC.
REQ-012 In IDLE, accepting an illegal opcode SHALL pulse illegal for the next cycle, perform no register write and remain in IDLE.
REQ-013 alu_a, alu_b and alu_op SHALL be registered and held stable throughout EXEC.
REQ-014 At the end of EXEC, alu_result SHALL be captured into res_q and the FSM SHALL go to WB.
REQ-015 In WB, done SHALL be 1; at the end of WB, reg[rd] <= res_q and the FSM SHALL go to IDLE.
REQ-016 Latency SHALL be 3 cycles from acceptance to reg[rd] update for ALU ops; a new byte may be accepted in the cycle after WB.
REQ-017 Arithmetic SHALL be modulo 256; the ALU owns wrap-around and the block ignores carry.
REQ-018 rd==rs SHALL be legal, with both operands equal to the pre-instruction value.
REQ-019 In IMM with instr_valid=0, the block SHALL wait indefinitely with outputs unchanged.
REQ-020 dbg_data SHALL reflect a WB write from the cycle after the write edge.

Reset
REQ-021 On rst_n=0, the block SHALL go to IDLE.
REQ-022 On rst_n=0, reg[0..3], res_q, alu_a, alu_b, alu_op, done, illegal and z_flag SHALL all be 0.
REQ-023 An asserted rst_n mid-operation (IMM, EXEC or WB) SHALL abort the instruction with no register write and no done pulse.
REQ-024 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-025 With EXEC_CONTROL_ZFLAG_EN defined, z_flag SHALL be registered and set to (res_q==0) on each WB edge, holding between writes.
REQ-026 Without EXEC_CONTROL_ZFLAG_EN, z_flag SHALL be tied to 0 and no flag register SHALL exist.

Verification
REQ-027 Bench SHALL cover:
- LDI rd=1 with imm 0x7F, then ADD rd=1 rs=1 -> alu_op=0000, alu_a=alu_b=0x7F in EXEC, dbg reg1=0xFE, done pulses once.
- LDI r2=0x05, LDI r3=0x07, SUB r2,r3 -> reg2=0xFE; with the macro defined, SUB r2,r2 -> reg2=0x00 and z_flag=1.
- Instruction 0xC0 (illegal) -> illegal pulses 1 cycle, no done, all registers unchanged, instr_ready=1 next cycle.
- LDI accepted, then instr_valid low for 10 cycles -> FSM stays in IMM and instr_ready=1; immediate 0xA5 accepted -> reg[rd]=0xA5.
- rst_n asserted during EXEC of ADD -> no done, all registers 0, instr_ready=1 after release.
- Back-to-back ALU ops with instr_valid held 1 -> exactly one acceptance every 3 cycles.

Source files
------------

// File: rtl/exec_control_if.sv
// Bus bundle between exec_control and its upstream byte source, external ALU and debug port.
interface exec_control_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       done;
  logic       illegal;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       z_flag;

  modport master (
    output instr_valid, instr, alu_result, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_op, done, illegal, dbg_data, z_flag
  );

  modport slave (
    input  instr_valid, instr, alu_result, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_op, done, illegal, dbg_data, z_flag
  );
endinterface

// File: rtl/exec_control.sv
// exec_control: byte-serial instruction sequencer driving an external ALU over four 8-bit registers.
// Optional feature: define EXEC_CONTROL_ZFLAG_EN for a registered zero flag updated on each write-back.
module exec_control (
  input logic           clk,
  input logic           rst_n,
  exec_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IMM, EXEC, WB} state_t;

  state_t     state_q;
  logic [7:0] regs_q [4];
  logic [7:0] res_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_op_q;
  logic [1:0] rd_q;
  logic       done_q;
  logic       illegal_q;

  logic [2:0] opc_d;
  logic [1:0] rd_d;
  logic [1:0] rs_d;
  logic [3:0] op_d;
  logic       legal_d;
  logic       ldi_d;
  logic       accept_d;
  logic       unused_instr_bit;

  assign opc_d            = bus.instr[7:5];
  assign rd_d             = bus.instr[3:2];
  assign rs_d             = bus.instr[1:0];
  assign unused_instr_bit = bus.instr[4];

  assign bus.instr_ready = (state_q == IDLE) || (state_q == IMM);
  assign accept_d        = bus.instr_valid && bus.instr_ready;

  always_comb begin
    op_d    = 4'b0000;
    legal_d = 1'b1;
    ldi_d   = 1'b0;
    case (opc_d)
      3'b000:  op_d = 4'b0000;
      3'b001:  op_d = 4'b0001;
      3'b010:  op_d = 4'b0010;
      3'b011:  op_d = 4'b0011;
      3'b100:  op_d = 4'b0100;
      3'b101: begin
        op_d  = 4'b0010;
        ldi_d = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
  end

`ifdef EXEC_CONTROL_ZFLAG_EN
  logic z_q;
  assign bus.z_flag = z_q;
`else
  assign bus.z_flag = 1'b0;
`endif

  // done and illegal are one-cycle pulses, so they default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      regs_q[0] <= 8'h00;
      regs_q[1] <= 8'h00;
      regs_q[2] <= 8'h00;
      regs_q[3] <= 8'h00;
      res_q     <= 8'h00;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_op_q  <= 4'b0000;
      rd_q      <= 2'b00;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_CONTROL_ZFLAG_EN
      z_q       <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (!legal_d) begin
              illegal_q <= 1'b1;
            end else if (ldi_d) begin
              rd_q    <= rd_d;
              state_q <= IMM;
            end else begin
              rd_q     <= rd_d;
              alu_a_q  <= regs_q[rd_d];
              alu_b_q  <= regs_q[rs_d];
              alu_op_q <= op_d;
              state_q  <= EXEC;
            end
          end
        end
        IMM: begin
          if (accept_d) begin
            alu_a_q  <= regs_q[rd_q];
            alu_b_q  <= bus.instr;
            alu_op_q <= 4'b0010;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= bus.alu_result;
          done_q  <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          regs_q[rd_q] <= res_q;
`ifdef EXEC_CONTROL_ZFLAG_EN
          z_q          <= (res_q == 8'h00);
`endif
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
  assign bus.dbg_data = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_exec_control.sv
// Directed, table-driven bench for exec_control with a behavioural ALU on the alu_* bus.
module tb_exec_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef EXEC_CONTROL_ZFLAG_EN
  localparam bit ZF_EN = 1'b1;
`else
  localparam bit ZF_EN = 1'b0;
`endif

  exec_control_if bus();

  exec_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: MOV/LDI pass operand b through, arithmetic wraps at 8 bits
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_b;
      4'b0011: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0100: bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] instr;
    logic       hasImm;
    logic [7:0] imm;
    logic [3:0] expOp;
    logic [7:0] expA;
    logic [7:0] expB;
    logic [1:0] chkReg;
    logic [7:0] expReg;
    logic       expZ;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkReg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    bus.dbg_addr = idx;
    #1;
    checkOutput(name, bus.dbg_data, exp);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the write-back edge
  task automatic applyStimulus(input logic [7:0] ins, input logic hasImm, input logic [7:0] imm,
                               input logic [3:0] expOp, input logic [7:0] expA,
                               input logic [7:0] expB);
    int doneCount;
    doneCount = 0;
    checkBit("ready_idle", bus.instr_ready, 1'b1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk); @(negedge clk);
    if (hasImm) begin
      checkBit("ready_imm", bus.instr_ready, 1'b1);
      bus.instr = imm;
      @(posedge clk); @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    checkBit("ready_exec", bus.instr_ready, 1'b0);
    checkOutput("alu_op_exec", {4'h0, bus.alu_op}, {4'h0, expOp});
    checkOutput("alu_a_exec", bus.alu_a, expA);
    checkOutput("alu_b_exec", bus.alu_b, expB);
    if (bus.done) doneCount++;
    @(posedge clk); @(negedge clk);
    if (bus.done) doneCount++;
    checkBit("ready_wb", bus.instr_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    if (bus.done) doneCount++;
    checkOutput("done_count", 8'(doneCount), 8'd1);
    checkBit("ready_after_wb", bus.instr_ready, 1'b1);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.dbg_addr    = 2'd0;

    vecs[0] = '{8'hA4, 1'b1, 8'h7F, 4'h2, 8'h00, 8'h7F, 2'd1, 8'h7F, 1'b0};
    vecs[1] = '{8'h05, 1'b0, 8'h00, 4'h0, 8'h7F, 8'h7F, 2'd1, 8'hFE, 1'b0};
    vecs[2] = '{8'hA8, 1'b1, 8'h05, 4'h2, 8'h00, 8'h05, 2'd2, 8'h05, 1'b0};
    vecs[3] = '{8'hAC, 1'b1, 8'h07, 4'h2, 8'h00, 8'h07, 2'd3, 8'h07, 1'b0};
    vecs[4] = '{8'h2B, 1'b0, 8'h00, 4'h1, 8'h05, 8'h07, 2'd2, 8'hFE, 1'b0};
    vecs[5] = '{8'h6D, 1'b0, 8'h00, 4'h3, 8'h07, 8'hFE, 2'd3, 8'h06, 1'b0};
    vecs[6] = '{8'h83, 1'b0, 8'h00, 4'h4, 8'h00, 8'h06, 2'd0, 8'h06, 1'b0};
    vecs[7] = '{8'h41, 1'b0, 8'h00, 4'h2, 8'h06, 8'hFE, 2'd0, 8'hFE, 1'b0};
    vecs[8] = '{8'h13, 1'b0, 8'h00, 4'h0, 8'hFE, 8'h06, 2'd0, 8'h04, 1'b0};
    vecs[9] = '{8'h2A, 1'b0, 8'h00, 4'h1, 8'hFE, 8'hFE, 2'd2, 8'h00, 1'b1};

    // Reset state
    @(negedge clk); @(negedge clk);
    checkBit("rst_done", bus.done, 1'b0);
    checkBit("rst_illegal", bus.illegal, 1'b0);
    checkBit("rst_z", bus.z_flag, 1'b0);
    checkOutput("rst_alu_a", bus.alu_a, 8'h00);
    checkOutput("rst_alu_b", bus.alu_b, 8'h00);
    checkOutput("rst_alu_op", {4'h0, bus.alu_op}, 8'h00);
    for (int r = 0; r < 4; r++) checkReg("rst_reg", 2'(r), 8'h00);
    rst_n = 1'b1;
    #1;
    checkBit("ready_after_rst", bus.instr_ready, 1'b1);
    @(negedge clk);

    // Main instruction table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].hasImm, vecs[i].imm,
                    vecs[i].expOp, vecs[i].expA, vecs[i].expB);
      checkReg("vec_reg", vecs[i].chkReg, vecs[i].expReg);
      checkBit("vec_z", bus.z_flag, ZF_EN ? vecs[i].expZ : 1'b0);
    end
    checkReg("final_r0", 2'd0, 8'h04);
    checkReg("final_r1", 2'd1, 8'hFE);
    checkReg("final_r2", 2'd2, 8'h00);
    checkReg("final_r3", 2'd3, 8'h06);

    // Illegal opcodes 110 and 111
    for (int k = 0; k < 2; k++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = (k == 0) ? 8'hC0 : 8'hE3;
      @(posedge clk); @(negedge clk);
      bus.instr_valid = 1'b0;
      checkBit("illegal_pulse", bus.illegal, 1'b1);
      checkBit("illegal_no_done", bus.done, 1'b0);
      checkBit("illegal_ready", bus.instr_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      checkBit("illegal_cleared", bus.illegal, 1'b0);
      checkBit("illegal_no_done2", bus.done, 1'b0);
      checkBit("illegal_z_hold", bus.z_flag, ZF_EN);
    end
    checkReg("ill_r0", 2'd0, 8'h04);
    checkReg("ill_r1", 2'd1, 8'hFE);
    checkReg("ill_r2", 2'd2, 8'h00);
    checkReg("ill_r3", 2'd3, 8'h06);

    // LDI r1 with a 10-cycle stall before the immediate
    bus.instr_valid = 1'b1;
    bus.instr       = 8'hA4;
    @(posedge clk); @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      checkBit("stall_ready", bus.instr_ready, 1'b1);
      checkBit("stall_done", bus.done, 1'b0);
      checkOutput("stall_alu_b", bus.alu_b, 8'hFE);
      @(posedge clk); @(negedge clk);
    end
    bus.instr_valid = 1'b1;
    bus.instr       = 8'hA5;
    @(posedge clk); @(negedge clk);
    bus.instr_valid = 1'b0;
    checkOutput("stall_exec_a", bus.alu_a, 8'hFE);
    checkOutput("stall_exec_b", bus.alu_b, 8'hA5);
    checkOutput("stall_exec_op", {4'h0, bus.alu_op}, 8'h02);
    @(posedge clk); @(negedge clk);
    checkBit("stall_done_wb", bus.done, 1'b1);
    @(posedge clk); @(negedge clk);
    checkReg("stall_r1", 2'd1, 8'hA5);

    // Reset asserted during EXEC of ADD r1,r1
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h05;
    @(posedge clk); @(negedge clk);
    bus.instr_valid = 1'b0;
    checkOutput("abort_exec_a", bus.alu_a, 8'hA5);
    rst_n = 1'b0;
    #1;
    checkBit("abort_done", bus.done, 1'b0);
    checkBit("abort_z", bus.z_flag, 1'b0);
    checkOutput("abort_alu_a", bus.alu_a, 8'h00);
    checkOutput("abort_alu_b", bus.alu_b, 8'h00);
    for (int r = 0; r < 4; r++) checkReg("abort_reg", 2'(r), 8'h00);
    @(posedge clk); @(negedge clk);
    checkBit("abort_done2", bus.done, 1'b0);
    rst_n = 1'b1;
    #1;
    checkBit("abort_ready", bus.instr_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    checkBit("abort_done3", bus.done, 1'b0);
    checkReg("abort_r1_after", 2'd1, 8'h00);

    // Back-to-back ADD r0,r0 with instr_valid held high
    applyStimulus(8'hA0, 1'b1, 8'h01, 4'h2, 8'h00, 8'h01);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h00;
    begin
      int accepts;
      accepts = 0;
      for (int c = 0; c < 9; c++) begin
        if (bus.instr_ready) accepts++;
        checkBit("b2b_accept_slot", bus.instr_ready, (c % 3) == 0);
        checkBit("b2b_done_slot", bus.done, (c % 3) == 2);
        if ((c % 3) == 1) checkOutput("b2b_alu_a", bus.alu_a, 8'(1 << (c / 3)));
        @(posedge clk); @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      checkOutput("b2b_accepts", 8'(accepts), 8'd3);
    end
    checkReg("b2b_r0", 2'd0, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
